// File: rtl/ravenoc_pkg.sv
// Shared router types: flit layout, flit type encoding and VC sizing.
// Also carries the state encoding of the VC output arbiter.
package ravenoc_pkg;

    localparam int unsigned N_VIRT_CHN      = 4;
    localparam int unsigned FLIT_WIDTH      = 34;
    localparam int unsigned VC_WIDTH        = $clog2(N_VIRT_CHN);
    localparam int unsigned PKT_SIZE_WIDTH  = 8;
    localparam int unsigned FLIT_DATA_WIDTH = FLIT_WIDTH - 2 - PKT_SIZE_WIDTH;

    localparam logic [PKT_SIZE_WIDTH-1:0] MIN_SIZE_FLIT = 'd1;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    typedef struct packed {
        flit_type_t                  type_f;
        logic [PKT_SIZE_WIDTH-1:0]   pkt_size;
        logic [FLIT_DATA_WIDTH-1:0]  data;
    } s_flit_head_data_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vc_output_arb_if.sv
// Bundle of the per-VC input stream and the single registered output stream.
// Signal suffixes are from the arbiter's point of view.
interface vc_output_arb_if;

    logic [ravenoc_pkg::N_VIRT_CHN-1:0][ravenoc_pkg::FLIT_WIDTH-1:0] fdata_i;
    logic [ravenoc_pkg::N_VIRT_CHN-1:0]                              valid_i;
    logic [ravenoc_pkg::N_VIRT_CHN-1:0]                              ready_o;
    logic [ravenoc_pkg::FLIT_WIDTH-1:0]                              fdata_o;
    logic [ravenoc_pkg::VC_WIDTH-1:0]                                vc_id_o;
    logic                                                            valid_o;
    logic                                                            ready_i;
    logic                                                            err_o;

    // Arbiter side.
    modport slave (
        input  fdata_i, valid_i, ready_i,
        output ready_o, fdata_o, vc_id_o, valid_o, err_o
    );

    // VC buffers plus router control side.
    modport master (
        output fdata_i, valid_i, ready_i,
        input  ready_o, fdata_o, vc_id_o, valid_o, err_o
    );

endinterface

// File: rtl/vc_output_arb_prio_enc.sv
// Fixed-priority encoder: the highest set request index wins.
// Gives both the index and the one-hot form of the winner.
module prio_enc #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_oh_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    always_comb begin
        gnt_idx_o = '0;
        // Ascending scan so the last (highest) hit overrides lower ones.
        for (int i = 0; i < int'(N); i++) begin
            if (req_i[i]) begin
                gnt_idx_o = IdxW'(i);
            end
        end
    end

    always_comb begin
        any_o    = |req_i;
        gnt_oh_o = '0;
        if (any_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/vc_output_arb.sv
// Picks one VC buffer output (highest index wins), holds the grant for a whole
// multi-flit packet and presents the flit through a registered valid/ready stage.
module vc_output_arb
    import ravenoc_pkg::*;
(
    input  logic            clk,
    input  logic            arst,
    vc_output_arb_if.slave  bus
);

    arb_state_t               state_q, state_d;
    logic [VC_WIDTH-1:0]      lock_vc_q, lock_vc_d;

    logic [FLIT_WIDTH-1:0]    fdata_q;
    logic [VC_WIDTH-1:0]      vc_id_q;
    logic                     valid_q;
    logic                     err_q;

    logic [N_VIRT_CHN-1:0]    enc_oh;
    logic [VC_WIDTH-1:0]      enc_idx;
    logic                     enc_any;

    logic [N_VIRT_CHN-1:0]    ready;
    logic [VC_WIDTH-1:0]      gnt;
    logic                     load_ok;
    logic                     xfer;
    logic                     fwd;
    logic                     err_d;
    s_flit_head_data_t        flit;

    prio_enc #(
        .N (N_VIRT_CHN)
    ) u_prio_enc (
        .req_i     (bus.valid_i),
        .gnt_oh_o  (enc_oh),
        .gnt_idx_o (enc_idx),
        .any_o     (enc_any)
    );

    // Grant and per-VC pop. While locked only the locked VC may be popped.
    always_comb begin
        load_ok = ~valid_q | bus.ready_i;
        ready   = '0;
        if (state_q == ARB_LOCKED) begin
            gnt               = lock_vc_q;
            ready[lock_vc_q]  = load_ok;
        end else begin
            gnt   = enc_idx;
            ready = enc_any ? (enc_oh & {N_VIRT_CHN{load_ok}}) : '0;
        end
        xfer = |(bus.valid_i & ready);
        flit = s_flit_head_data_t'(bus.fdata_i[gnt]);
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        fwd       = 1'b0;
        err_d     = 1'b0;
        if (xfer) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (flit.type_f == HEAD_FLIT) begin
                        fwd = 1'b1;
                        if (flit.pkt_size != MIN_SIZE_FLIT) begin
                            state_d   = ARB_LOCKED;
                            lock_vc_d = gnt;
                        end
                    end else begin
                        // Orphan body/tail: pop and drop it.
                        err_d = 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    fwd = 1'b1;
                    if (flit.type_f == TAIL_FLIT) begin
                        state_d = ARB_IDLE;
                    end else if (flit.type_f != BODY_FLIT) begin
                        // Stray head inside a packet: keep it flowing, keep the lock.
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ARB_IDLE;
            lock_vc_q <= '0;
            fdata_q   <= '0;
            vc_id_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            err_q     <= err_d;
            if (fwd) begin
                fdata_q <= flit;
                vc_id_q <= gnt;
                valid_q <= 1'b1;
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.fdata_o = fdata_q;
    assign bus.vc_id_o = vc_id_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_vc_output_arb.sv
// Directed bench for vc_output_arb: priority, packet locking, backpressure,
// protocol errors, reset mid-packet and back-to-back throughput.
module tb_vc_output_arb;
    import ravenoc_pkg::*;

    logic clk;
    logic arst;
    int   tests;
    int   fails;

    vc_output_arb_if bus ();

    vc_output_arb dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FLIT_WIDTH-1:0] mk(input flit_type_t t, input int unsigned sz,
                                                  input int unsigned d);
        s_flit_head_data_t f;
        f.type_f   = t;
        f.pkt_size = PKT_SIZE_WIDTH'(sz);
        f.data     = FLIT_DATA_WIDTH'(d);
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst        = 1'b1;
        bus.valid_i = '0;
        bus.fdata_i = '0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        tests++;
        if (bus.fdata_o !== '0) begin fails++; $display("FAIL reset_fdata: got %h want 0", bus.fdata_o); end
        tests++;
        if (bus.vc_id_o !== '0) begin fails++; $display("FAIL reset_vc_id: got %0d want 0", bus.vc_id_o); end
        tests++;
        if (bus.err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        tests++;
        if (bus.ready_o !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", bus.ready_o); end
        arst = 1'b0;
        step();
    endtask

    task automatic test_priority();
        logic [FLIT_WIDTH-1:0] f0, f1;
        f0 = mk(HEAD_FLIT, 1, 'hA0);
        f1 = mk(HEAD_FLIT, 1, 'hA1);
        bus.valid_i = 4'b0101;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0100) begin fails++; $display("FAIL prio_0101: got %b want 0100", bus.ready_o); end
        bus.valid_i = 4'b1111;
        #1;
        tests++;
        if (bus.ready_o !== 4'b1000) begin fails++; $display("FAIL prio_1111: got %b want 1000", bus.ready_o); end
        bus.fdata_i[0] = f0;
        bus.fdata_i[1] = f1;
        bus.valid_i    = 4'b0011;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0010) begin fails++; $display("FAIL prio_0011: got %b want 0010", bus.ready_o); end
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd1 || bus.fdata_o !== f1) begin
            fails++;
            $display("FAIL prio_first: got v=%b vc=%0d d=%h want v=1 vc=1 d=%h",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, f1);
        end
        bus.valid_i = 4'b0001;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0001) begin fails++; $display("FAIL prio_idle_vc0: got %b want 0001", bus.ready_o); end
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd0 || bus.fdata_o !== f0) begin
            fails++;
            $display("FAIL prio_second: got v=%b vc=%0d d=%h want v=1 vc=0 d=%h",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, f0);
        end
        bus.valid_i = '0;
        step();
        tests++;
        if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL prio_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_packet_lock();
        logic [FLIT_WIDTH-1:0] seq [3];
        logic [FLIT_WIDTH-1:0] h1;
        seq[0] = mk(HEAD_FLIT, 3, 'h10);
        seq[1] = mk(BODY_FLIT, 3, 'h11);
        seq[2] = mk(TAIL_FLIT, 3, 'h12);
        h1     = mk(HEAD_FLIT, 1, 'hB1);
        for (int i = 0; i < 3; i++) begin
            bus.fdata_i[0] = seq[i];
            bus.fdata_i[1] = h1;
            bus.valid_i    = (i == 0) ? 4'b0001 : 4'b0011;
            #1;
            tests++;
            if (bus.ready_o !== 4'b0001) begin
                fails++;
                $display("FAIL lock_ready[%0d]: got %b want 0001", i, bus.ready_o);
            end
            step();
            tests++;
            if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd0 || bus.fdata_o !== seq[i]) begin
                fails++;
                $display("FAIL lock_out[%0d]: got v=%b vc=%0d d=%h want v=1 vc=0 d=%h",
                         i, bus.valid_o, bus.vc_id_o, bus.fdata_o, seq[i]);
            end
        end
        bus.valid_i = 4'b0010;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0010) begin fails++; $display("FAIL lock_release: got %b want 0010", bus.ready_o); end
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd1 || bus.fdata_o !== h1) begin
            fails++;
            $display("FAIL lock_vc1: got v=%b vc=%0d d=%h want v=1 vc=1 d=%h",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, h1);
        end
        bus.valid_i = '0;
        step();
    endtask

    task automatic test_backpressure();
        logic [FLIT_WIDTH-1:0] seq [4];
        seq[0] = mk(HEAD_FLIT, 4, 'h40);
        seq[1] = mk(BODY_FLIT, 4, 'h41);
        seq[2] = mk(BODY_FLIT, 4, 'h42);
        seq[3] = mk(TAIL_FLIT, 4, 'h43);
        bus.valid_i = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            bus.fdata_i[1] = seq[i];
            step();
        end
        bus.fdata_i[1] = seq[2];
        bus.ready_i    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (bus.ready_o !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus.ready_o); end
            step();
            tests++;
            if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd1 || bus.fdata_o !== seq[1]) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b vc=%0d d=%h want v=1 vc=1 d=%h",
                         c, bus.valid_o, bus.vc_id_o, bus.fdata_o, seq[1]);
            end
        end
        bus.ready_i = 1'b1;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0010) begin fails++; $display("FAIL bp_resume: got %b want 0010", bus.ready_o); end
        for (int i = 2; i < 4; i++) begin
            bus.fdata_i[1] = seq[i];
            step();
            tests++;
            if (bus.valid_o !== 1'b1 || bus.fdata_o !== seq[i]) begin
                fails++;
                $display("FAIL bp_after[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.valid_o, bus.fdata_o, seq[i]);
            end
        end
        bus.valid_i = '0;
        step();
        tests++;
        if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_idle_body_err();
        bus.fdata_i[1] = mk(BODY_FLIT, 2, 'h55);
        bus.valid_i    = 4'b0010;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0010) begin fails++; $display("FAIL err_pop: got %b want 0010", bus.ready_o); end
        step();
        bus.valid_i = '0;
        tests++;
        if (bus.valid_o !== 1'b0 || bus.err_o !== 1'b1) begin
            fails++;
            $display("FAIL err_pulse: got v=%b err=%b want v=0 err=1", bus.valid_o, bus.err_o);
        end
        step();
        tests++;
        if (bus.valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_end: got v=%b err=%b want v=0 err=0", bus.valid_o, bus.err_o);
        end
    endtask

    task automatic test_locked_head_err();
        logic [FLIT_WIDTH-1:0] h3, hx, t2, h31;
        h3  = mk(HEAD_FLIT, 3, 'h21);
        hx  = mk(HEAD_FLIT, 1, 'h22);
        t2  = mk(TAIL_FLIT, 3, 'h23);
        h31 = mk(HEAD_FLIT, 1, 'h31);
        bus.fdata_i[2] = h3;
        bus.valid_i    = 4'b0100;
        step();
        bus.fdata_i[2] = hx;
        bus.fdata_i[3] = h31;
        bus.valid_i    = 4'b1100;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0100) begin fails++; $display("FAIL lhead_nopreempt: got %b want 0100", bus.ready_o); end
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.fdata_o !== hx || bus.vc_id_o !== 2'd2 || bus.err_o !== 1'b1) begin
            fails++;
            $display("FAIL lhead_fwd: got v=%b vc=%0d d=%h err=%b want v=1 vc=2 d=%h err=1",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, bus.err_o, hx);
        end
        bus.fdata_i[2] = t2;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0100) begin fails++; $display("FAIL lhead_still_locked: got %b want 0100", bus.ready_o); end
        step();
        tests++;
        if (bus.fdata_o !== t2 || bus.err_o !== 1'b0) begin
            fails++;
            $display("FAIL lhead_tail: got d=%h err=%b want d=%h err=0", bus.fdata_o, bus.err_o, t2);
        end
        bus.valid_i = 4'b1000;
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd3 || bus.fdata_o !== h31) begin
            fails++;
            $display("FAIL lhead_vc3: got v=%b vc=%0d d=%h want v=1 vc=3 d=%h",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, h31);
        end
        bus.valid_i = '0;
        step();
    endtask

    task automatic test_arst_mid_packet();
        logic [FLIT_WIDTH-1:0] h0;
        h0 = mk(HEAD_FLIT, 1, 'h77);
        bus.fdata_i[1] = mk(HEAD_FLIT, 4, 'h60);
        bus.valid_i    = 4'b0010;
        step();
        bus.fdata_i[1] = mk(BODY_FLIT, 4, 'h61);
        step();
        arst        = 1'b1;
        bus.valid_i = '0;
        #1;
        tests++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 4'b0000 || bus.err_o !== 1'b0) begin
            fails++;
            $display("FAIL arst_now: got v=%b rdy=%b err=%b want v=0 rdy=0000 err=0",
                     bus.valid_o, bus.ready_o, bus.err_o);
        end
        step();
        arst           = 1'b0;
        bus.fdata_i[0] = h0;
        bus.valid_i    = 4'b0001;
        #1;
        tests++;
        if (bus.ready_o !== 4'b0001) begin fails++; $display("FAIL arst_idle_grant: got %b want 0001", bus.ready_o); end
        step();
        tests++;
        if (bus.valid_o !== 1'b1 || bus.vc_id_o !== 2'd0 || bus.fdata_o !== h0) begin
            fails++;
            $display("FAIL arst_vc0: got v=%b vc=%0d d=%h want v=1 vc=0 d=%h",
                     bus.valid_o, bus.vc_id_o, bus.fdata_o, h0);
        end
        bus.valid_i = '0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [FLIT_WIDTH-1:0] seq [8];
        for (int p = 0; p < 2; p++) begin
            seq[p*4+0] = mk(HEAD_FLIT, 4, 'h80 + p*4);
            seq[p*4+1] = mk(BODY_FLIT, 4, 'h81 + p*4);
            seq[p*4+2] = mk(BODY_FLIT, 4, 'h82 + p*4);
            seq[p*4+3] = mk(TAIL_FLIT, 4, 'h83 + p*4);
        end
        bus.valid_i = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            bus.fdata_i[1] = seq[i];
            step();
            tests++;
            if (bus.valid_o !== 1'b1 || bus.fdata_o !== seq[i]) begin
                fails++;
                $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.valid_o, bus.fdata_o, seq[i]);
            end
        end
        bus.valid_i = '0;
        step();
        tests++;
        if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", bus.valid_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_priority();
        test_packet_lock();
        test_backpressure();
        test_idle_body_err();
        test_locked_head_err();
        test_arst_mid_packet();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
